// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and aluControl.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // Instruction classes seen by the sequencer; everything else is a NOP.
  typedef enum logic [3:0] {
    IC_NOP   = 4'd0,
    IC_RTYPE = 4'd1,
    IC_JR    = 4'd2,
    IC_LW    = 4'd3,
    IC_SW    = 4'd4,
    IC_BEQ   = 4'd5,
    IC_BNE   = 4'd6,
    IC_J     = 4'd7,
    IC_IMM   = 4'd8
  } iclass_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [3:0] ALU_OP_ADD   = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB   = 4'b0001;
  localparam logic [3:0] ALU_OP_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_OP_AND   = 4'b0011;
  localparam logic [3:0] ALU_OP_OR    = 4'b0100;
  localparam logic [3:0] ALU_OP_XOR   = 4'b0101;
  localparam logic [3:0] ALU_OP_SLT   = 4'b0110;
  localparam logic [3:0] ALU_OP_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_OP_LUI   = 4'b1000;

  localparam logic [1:0] PC_SRC_PC4  = 2'b00;
  localparam logic [1:0] PC_SRC_BR   = 2'b01;
  localparam logic [1:0] PC_SRC_JMP  = 2'b10;
  localparam logic [1:0] PC_SRC_REG  = 2'b11;

  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_SEXT   = 2'b10;
  localparam logic [1:0] ALUB_ZEXT   = 2'b11;

  typedef struct packed {
    iclass_t    cls;
    logic [3:0] alu_op;
    logic [1:0] alu_src_b;
  } dec_t;

endpackage

// File: rtl/mips_opcode_decode.sv
// Combinational opcode/funct decode: instruction class plus the ALU
// operation and B-operand source used during EXEC/MEM/WB.
module mips_opcode_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // Table lookup; unknown opcodes fall through as NOP with ADD/rt.
  always_comb begin
    dec.cls       = IC_NOP;
    dec.alu_op    = ALU_OP_ADD;
    dec.alu_src_b = ALUB_RT;
    unique case (opcode)
      OP_RTYPE: begin
        dec.cls       = (funct == FN_JR) ? IC_JR : IC_RTYPE;
        dec.alu_op    = ALU_OP_RTYPE;
        dec.alu_src_b = ALUB_RT;
      end
      OP_LW: begin
        dec.cls       = IC_LW;
        dec.alu_src_b = ALUB_SEXT;
      end
      OP_SW: begin
        dec.cls       = IC_SW;
        dec.alu_src_b = ALUB_SEXT;
      end
      OP_BEQ: begin
        dec.cls    = IC_BEQ;
        dec.alu_op = ALU_OP_SUB;
      end
      OP_BNE: begin
        dec.cls    = IC_BNE;
        dec.alu_op = ALU_OP_SUB;
      end
      OP_J:     dec.cls = IC_J;
      OP_ADDIU: begin
        dec.cls       = IC_IMM;
        dec.alu_src_b = ALUB_SEXT;
      end
      OP_ANDI: begin
        dec.cls       = IC_IMM;
        dec.alu_op    = ALU_OP_AND;
        dec.alu_src_b = ALUB_ZEXT;
      end
      OP_ORI: begin
        dec.cls       = IC_IMM;
        dec.alu_op    = ALU_OP_OR;
        dec.alu_src_b = ALUB_ZEXT;
      end
      OP_XORI: begin
        dec.cls       = IC_IMM;
        dec.alu_op    = ALU_OP_XOR;
        dec.alu_src_b = ALUB_ZEXT;
      end
      OP_SLTI: begin
        dec.cls       = IC_IMM;
        dec.alu_op    = ALU_OP_SLT;
        dec.alu_src_b = ALUB_SEXT;
      end
      OP_SLTIU: begin
        dec.cls       = IC_IMM;
        dec.alu_op    = ALU_OP_SLTU;
        dec.alu_src_b = ALUB_SEXT;
      end
      OP_LUI: begin
        dec.cls       = IC_IMM;
        dec.alu_op    = ALU_OP_LUI;
        dec.alu_src_b = ALUB_ZEXT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory wait handling, datapath enables and halt-on-jump-to-zero.
module mips_control_fsm
  import mips_pkg::*;
#(
  parameter bit RESET_TO_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_waitrequest,
  input  logic       next_pc_zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [3:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       active,
  output logic [2:0] state
);

  state_t st, nxt;
  dec_t   dec;

  mips_opcode_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .dec    (dec)
  );

  // State register; reset overrides everything, so an in-flight memory
  // access is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) st <= RESET_TO_FETCH ? S_FETCH : S_IDLE;
    else       st <= nxt;
  end

  // Outputs decoded from the state register. ir_write/pc_write must react
  // to mem_waitrequest and alu_zero in the same cycle, so they cannot be
  // registered; all outputs are forced low while reset is asserted.
  always_comb begin
    nxt        = st;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PC4;
    alu_op     = ALU_OP_ADD;
    alu_src_b  = ALUB_RT;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    unique case (st)
      S_IDLE: if (start) nxt = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (!mem_waitrequest) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_PC4;
          nxt      = S_DECODE;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        alu_op    = dec.alu_op;
        alu_src_b = dec.alu_src_b;
        unique case (dec.cls)
          IC_RTYPE, IC_IMM: nxt = S_WB;
          IC_LW, IC_SW:     nxt = S_MEM;
          IC_JR: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_REG;
            nxt      = S_FETCH;
          end
          IC_BEQ, IC_BNE: begin
            pc_write = (dec.cls == IC_BEQ) ? alu_zero : !alu_zero;
            pc_src   = PC_SRC_BR;
            nxt      = S_FETCH;
          end
          IC_J: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JMP;
            nxt      = S_FETCH;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        alu_op    = dec.alu_op;
        alu_src_b = ALUB_SEXT;
        mem_read  = (dec.cls == IC_LW);
        mem_write = (dec.cls == IC_SW);
        if (!mem_waitrequest) nxt = (dec.cls == IC_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        // Hold the EXEC ALU setup so an unregistered ALU result stays put.
        alu_op     = dec.alu_op;
        alu_src_b  = dec.alu_src_b;
        reg_write  = 1'b1;
        reg_dst    = (dec.cls == IC_RTYPE);
        mem_to_reg = (dec.cls == IC_LW);
        nxt        = S_FETCH;
      end
      S_HALT: nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    // Jumping to address 0 (including PC+4 wrap) stops the CPU.
    if (pc_write && next_pc_zero) nxt = S_HALT;
    if (reset) begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = PC_SRC_PC4;
      alu_op     = ALU_OP_ADD;
      alu_src_b  = ALUB_RT;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  assign active = (st != S_IDLE) && (st != S_HALT);
  assign state  = st;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Scoreboard bench: an instruction-level model pushes the expected per-cycle
// controller outputs; a negedge monitor pops and compares against the DUT.
module tb_mips_control_fsm;

  localparam int C_R = 0, C_JR = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5,
                 C_J = 6, C_IMM = 7, C_NOP = 8;

  typedef struct packed {
    logic [18:0] v;
    logic [18:0] m;
  } em_t;

  logic       clk = 1'b0;
  logic       reset, start, alu_zero, mem_waitrequest, next_pc_zero;
  logic       reset2, start2;
  logic [5:0] opcode, funct;

  logic       mr, mw, irw, pcw, rw, rd, m2r, act;
  logic [1:0] pcs, sb;
  logic [3:0] aop;
  logic [2:0] st;

  logic       mr2, mw2, irw2, pcw2, rw2, rd2, m2r2, act2;
  logic [1:0] pcs2, sb2;
  logic [3:0] aop2;
  logic [2:0] st2;

  int checks = 0;
  int failures = 0;

  logic [18:0] val_q[$];
  logic [18:0] msk_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  mips_control_fsm dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_waitrequest(mem_waitrequest), .next_pc_zero(next_pc_zero),
    .mem_read(mr), .mem_write(mw), .ir_write(irw), .pc_write(pcw), .pc_src(pcs),
    .alu_op(aop), .alu_src_b(sb), .reg_write(rw), .reg_dst(rd), .mem_to_reg(m2r),
    .active(act), .state(st)
  );

  mips_control_fsm #(.RESET_TO_FETCH(1'b0)) dut_idle (
    .clk(clk), .reset(reset2), .start(start2), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_waitrequest(mem_waitrequest), .next_pc_zero(next_pc_zero),
    .mem_read(mr2), .mem_write(mw2), .ir_write(irw2), .pc_write(pcw2), .pc_src(pcs2),
    .alu_op(aop2), .alu_src_b(sb2), .reg_write(rw2), .reg_dst(rd2), .mem_to_reg(m2r2),
    .active(act2), .state(st2)
  );

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Layout: state[18:16] mr mw irw pcw pcs[11:10] aop[9:6] sb[5:4] rw rd m2r act
  function automatic em_t rec(int s, bit r, bit w, bit i, bit p, logic [1:0] ps,
                              logic [3:0] ao, bit ca, logic [1:0] b, bit cb,
                              bit wr, bit d, bit m, bit a, bit cst);
    em_t e;
    e.v = {3'(s), r, w, i, p, ps, ao, b, wr, d, m, a};
    e.m = {cst ? 3'h7 : 3'h0, 4'hf, 2'h3, ca ? 4'hf : 4'h0, cb ? 2'h3 : 2'h0,
           3'h7, cst};
    return e;
  endfunction

  // Spec-level opcode table.
  function automatic void ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                  output int cls, output logic [3:0] ao,
                                  output logic [1:0] b);
    cls = C_NOP; ao = 4'b0000; b = 2'b00;
    case (op)
      6'b000000: begin cls = (fn == 6'b001000) ? C_JR : C_R; ao = 4'b0010; end
      6'b100011: begin cls = C_LW;  b = 2'b10; end
      6'b101011: begin cls = C_SW;  b = 2'b10; end
      6'b000100: begin cls = C_BEQ; ao = 4'b0001; end
      6'b000101: begin cls = C_BNE; ao = 4'b0001; end
      6'b000010: cls = C_J;
      6'b001001: begin cls = C_IMM; b = 2'b10; end
      6'b001100: begin cls = C_IMM; ao = 4'b0011; b = 2'b11; end
      6'b001101: begin cls = C_IMM; ao = 4'b0100; b = 2'b11; end
      6'b001110: begin cls = C_IMM; ao = 4'b0101; b = 2'b11; end
      6'b001010: begin cls = C_IMM; ao = 4'b0110; b = 2'b10; end
      6'b001011: begin cls = C_IMM; ao = 4'b0111; b = 2'b10; end
      6'b001111: begin cls = C_IMM; ao = 4'b1000; b = 2'b11; end
      default: ;
    endcase
  endfunction

  // One clock of stimulus: drive inputs, queue the expected outputs.
  task automatic cyc(input bit r, input bit s, input bit w, input bit z,
                     input bit npz, input em_t e, input string tag);
    reset = r; start = s; mem_waitrequest = w; alu_zero = z; next_pc_zero = npz;
    val_q.push_back(e.v); msk_q.push_back(e.m); tag_q.push_back(tag);
    @(posedge clk); #1;
  endtask

  // hsel: 0 none, 1 PC hits zero at fetch, 2 PC hits zero at EXEC pc_write.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                          input int mwt, input bit z, input int hsel,
                          input int rst_mem, output bit halted);
    int cls; logic [3:0] ao; logic [1:0] b; bit p; logic [1:0] ps;
    halted = 1'b0;
    ref_dec(op, fn, cls, ao, b);
    for (int i = 0; i < fw; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      cyc(0, rb(), 1, rb(), rb(), rec(1,1,0,0,0,2'b00,4'h0,1,2'b01,1,0,0,0,1,1), "fetch_wait");
    end
    opcode = 6'($urandom); funct = 6'($urandom);
    cyc(0, rb(), 0, rb(), hsel == 1, rec(1,1,0,1,1,2'b00,4'h0,1,2'b01,1,0,0,0,1,1), "fetch_done");
    if (hsel == 1) begin halted = 1'b1; return; end
    opcode = op; funct = fn;
    cyc(0, rb(), rb(), rb(), rb(), rec(2,0,0,0,0,2'b00,4'h0,1,2'b00,1,0,0,0,1,1), "decode");
    p = 1'b0; ps = 2'b00;
    case (cls)
      C_JR:  begin p = 1'b1; ps = 2'b11; end
      C_BEQ: begin p = z;    ps = 2'b01; end
      C_BNE: begin p = !z;   ps = 2'b01; end
      C_J:   begin p = 1'b1; ps = 2'b10; end
      default: ;
    endcase
    cyc(0, rb(), rb(), z, p ? (hsel == 2) : rb(),
        rec(3,0,0,0,p,ps,ao,1,b,1,0,0,0,1,1), "exec");
    if (p && hsel == 2) begin halted = 1'b1; return; end
    if (cls == C_LW || cls == C_SW) begin
      for (int i = 0; i <= mwt; i++) begin
        if (i == rst_mem) begin
          cyc(1, rb(), rb(), rb(), rb(), rec(4,0,0,0,0,2'b00,4'h0,1,2'b00,1,0,0,0,1,1), "mem_reset");
          return;
        end
        cyc(0, rb(), i != mwt, rb(), rb(),
            rec(4, cls == C_LW, cls == C_SW, 0,0,2'b00,4'h0,1,2'b10,1,0,0,0,1,1),
            (i == mwt) ? "mem_done" : "mem_wait");
      end
    end
    if (cls == C_R || cls == C_IMM || cls == C_LW)
      cyc(0, rb(), rb(), rb(), rb(),
          rec(5,0,0,0,0,2'b00,ao, ao == 4'h0, 2'b00,0,1, cls == C_R, cls == C_LW,1,1), "wb");
  endtask

  task automatic halt_and_reset(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, rb(), rb(), rb(), rb(), rec(6,0,0,0,0,2'b00,4'h0,1,2'b00,1,0,0,0,0,1), "halt");
    cyc(1, rb(), rb(), rb(), rb(), rec(6,0,0,0,0,2'b00,4'h0,1,2'b00,1,0,0,0,0,1), "halt_reset");
  endtask

  task automatic chk2(input string name, input logic [18:0] exp);
    logic [18:0] got;
    got = {st2, mr2, mw2, irw2, pcw2, pcs2, aop2, sb2, rw2, rd2, m2r2, act2};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%05h want=%05h", name, got, exp);
    end
  endtask

  // Monitor: compare every presented cycle against the scoreboard.
  always @(negedge clk) begin
    if (val_q.size() > 0) begin
      logic [18:0] got, v, m;
      string t;
      v = val_q.pop_front(); m = msk_q.pop_front(); t = tag_q.pop_front();
      got = {st, mr, mw, irw, pcw, pcs, aop, sb, rw, rd, m2r, act};
      checks++;
      if ((got & m) !== (v & m)) begin
        failures++;
        $display("FAIL %s t=%0t got=%05h want=%05h mask=%05h", t, $time, got, v, m);
      end
    end
  end

  initial begin
    logic [5:0] ops [13];
    bit h;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
            6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b001011,
            6'b001111};
    reset = 1; start = 0; alu_zero = 0; mem_waitrequest = 0; next_pc_zero = 0;
    reset2 = 1; start2 = 0; opcode = 0; funct = 0;
    @(posedge clk); #1;
    cyc(1, 1, 0, 0, 0, rec(0,0,0,0,0,2'b00,4'h0,1,2'b00,1,0,0,0,0,0), "reset_first");
    cyc(1, 1, 0, 0, 1, rec(1,0,0,0,0,2'b00,4'h0,1,2'b00,1,0,0,0,1,1), "reset_fetch");

    do_instr(6'b000000, 6'b100001, 0, 0, 0, 0, -1, h);   // ADDU
    do_instr(6'b100011, 6'h15, 2, 3, 0, 0, -1, h);       // LW with waits
    do_instr(6'b000100, 6'h00, 0, 0, 1, 0, -1, h);       // BEQ taken
    do_instr(6'b000100, 6'h00, 0, 0, 0, 0, -1, h);       // BEQ not taken
    do_instr(6'b000101, 6'h00, 0, 0, 1, 0, -1, h);       // BNE not taken
    do_instr(6'b000101, 6'h00, 1, 0, 0, 0, -1, h);       // BNE taken
    do_instr(6'b001101, 6'h3f, 0, 0, 0, 0, -1, h);       // ORI
    do_instr(6'b111111, 6'h00, 0, 0, 0, 0, -1, h);       // undefined -> NOP
    do_instr(6'b101011, 6'h00, 1, 2, 0, 0, -1, h);       // SW with waits

    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      int r, fw, mwt, hs, rm;
      r = $urandom_range(0, 13);
      op = (r == 13) ? 6'($urandom) : ops[r];
      fn = (op == 6'b000000 && $urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      fw = $urandom_range(0, 3);
      mwt = $urandom_range(0, 3);
      hs = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 2) : 0;
      rm = ($urandom_range(0, 19) == 0) ? $urandom_range(0, mwt) : -1;
      do_instr(op, fn, fw, mwt, rb(), hs, rm, h);
      if (h) halt_and_reset($urandom_range(1, 4));
    end

    do_instr(6'b000000, 6'b001000, 0, 0, 0, 2, -1, h);   // JR to 0
    halt_and_reset(10);
    do_instr(6'b001001, 6'h00, 1, 0, 0, 1, -1, h);       // PC+4 wraps to 0
    halt_and_reset(3);
    do_instr(6'b101011, 6'h00, 0, 5, 0, 0, 2, h);        // reset mid SW stall
    do_instr(6'b000000, 6'b100001, 0, 0, 0, 0, -1, h);

    reset = 0; mem_waitrequest = 1; next_pc_zero = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (val_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", val_q.size());
    end

    // RESET_TO_FETCH=0 instance: wait in IDLE until start.
    @(posedge clk); #1;
    reset2 = 1; start2 = 1;
    @(posedge clk); #1;
    chk2("idle_after_reset", 19'h0);
    reset2 = 0; start2 = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk2("idle_hold", 19'h0);
    end
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    chk2("idle_start_fetch", {3'd1, 1'b1, 3'b000, 2'b00, 4'h0, 2'b01, 4'b0001});
    reset2 = 1;
    @(posedge clk); #1;
    reset2 = 0;
    chk2("idle_reset_again", 19'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
